// File: rtl/mips32_multicycle.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mips32_multicycle
// Multi-cycle MIPS32 subset core: req/valid fetch, FSM sequencing, internal
// dmem, r0 tied to zero, retire counter. Define MIPS32_MC_BNE_EN to add bne.
// Revision : 1.0
// ============================================================================
module mips32_multicycle #(
  parameter int          IMEM_AW  = 8,
  parameter int          DMEM_AW  = 7,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic               clock,
  input  logic               reset,
  output logic               o_imem_req,
  output logic [IMEM_AW-1:0] o_imem_addr,
  input  logic               i_imem_valid,
  input  logic [31:0]        i_imem_data,
  output logic               o_retired,
  output logic [CNT_W-1:0]   o_retire_count,
  output logic               o_halted,
  output logic               o_illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t           r_state, w_next;
  logic [31:0]      r_pc, r_ir, r_a, r_b, r_imm, r_alu, r_mdr;
  logic [31:0]      r_regs [32];
  logic [31:0]      r_dmem [2**DMEM_AW];
  logic [CNT_W-1:0] r_count;
  logic             r_halted, r_illegal;

  logic [5:0]         w_op, w_funct;
  logic [4:0]         w_rs, w_rt, w_rd, w_shamt, w_dest;
  logic [15:0]        w_imm16;
  logic [25:0]        w_target;
  logic               w_is_rtype, w_is_break, w_legal, w_is_j, w_is_branch;
  logic               w_is_lw, w_is_sw, w_zext, w_taken;
  logic [31:0]        w_pc4, w_alu, w_rs_val, w_rt_val;
  logic [DMEM_AW-1:0] w_daddr;

  assign w_op       = r_ir[31:26];
  assign w_rs       = r_ir[25:21];
  assign w_rt       = r_ir[20:16];
  assign w_rd       = r_ir[15:11];
  assign w_shamt    = r_ir[10:6];
  assign w_funct    = r_ir[5:0];
  assign w_imm16    = r_ir[15:0];
  assign w_target   = r_ir[25:0];
  assign w_is_rtype = (w_op == 6'd0);
  assign w_is_break = w_is_rtype && (w_funct == 6'd13);
  assign w_is_j     = (w_op == 6'd2);
  assign w_is_lw    = (w_op == 6'd35);
  assign w_is_sw    = (w_op == 6'd43);
  assign w_zext     = (w_op == 6'd12) || (w_op == 6'd13) || (w_op == 6'd14);
  assign w_dest     = w_is_rtype ? w_rd : w_rt;
  assign w_pc4      = r_pc + 32'd4;
  assign w_daddr    = r_alu[DMEM_AW+1:2];
  assign w_rs_val   = (w_rs == 5'd0) ? 32'd0 : r_regs[w_rs];
  assign w_rt_val   = (w_rt == 5'd0) ? 32'd0 : r_regs[w_rt];

`ifdef MIPS32_MC_BNE_EN
  assign w_is_branch = (w_op == 6'd4) || (w_op == 6'd5);
  assign w_taken     = (w_op == 6'd5) ? (r_a != r_b) : (r_a == r_b);
`else
  assign w_is_branch = (w_op == 6'd4);
  assign w_taken     = (r_a == r_b);
`endif

  // break is classified separately; it is not in the legal set
  always_comb begin
    w_legal = 1'b0;
    case (w_op)
      6'd0: begin
        case (w_funct)
          6'd0, 6'd2, 6'd3, 6'd6, 6'd7, 6'd32, 6'd34,
          6'd36, 6'd37, 6'd38, 6'd39, 6'd42: w_legal = 1'b1;
          default:                           w_legal = 1'b0;
        endcase
      end
      6'd2, 6'd4, 6'd8, 6'd10, 6'd12, 6'd13, 6'd14, 6'd15, 6'd35, 6'd43: w_legal = 1'b1;
`ifdef MIPS32_MC_BNE_EN
      6'd5: w_legal = 1'b1;
`endif
      default: w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_alu = r_a + r_imm;
    if (w_is_rtype) begin
      case (w_funct)
        6'd0:    w_alu = r_b << w_shamt;
        6'd2:    w_alu = r_b >> w_shamt;
        6'd3:    w_alu = $signed(r_b) >>> w_shamt;
        6'd6:    w_alu = r_b >> r_a[4:0];
        6'd7:    w_alu = $signed(r_b) >>> r_a[4:0];
        6'd34:   w_alu = r_a - r_b;
        6'd36:   w_alu = r_a & r_b;
        6'd37:   w_alu = r_a | r_b;
        6'd38:   w_alu = r_a ^ r_b;
        6'd39:   w_alu = ~(r_a | r_b);
        6'd42:   w_alu = {31'd0, $signed(r_a) < $signed(r_b)};
        default: w_alu = r_a + r_b;
      endcase
    end else begin
      case (w_op)
        6'd10:   w_alu = {31'd0, $signed(r_a) < $signed(r_imm)};
        6'd12:   w_alu = r_a & r_imm;
        6'd13:   w_alu = r_a | r_imm;
        6'd14:   w_alu = r_a ^ r_imm;
        6'd15:   w_alu = {w_imm16, 16'd0};
        default: w_alu = r_a + r_imm;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // outputs are forced low while reset is held so the reset cycle is quiet
  always_comb begin
    w_next     = r_state;
    o_imem_req = 1'b0;
    o_retired  = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_imem_req = 1'b1;
        if (i_imem_valid) w_next = S_DECODE;
      end
      S_DECODE: begin
        if (w_is_break) begin
          o_retired = 1'b1;
          w_next    = S_HALT;
        end else if (!w_legal) begin
          w_next = S_HALT;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_is_branch || w_is_j) begin
          o_retired = 1'b1;
          w_next    = S_FETCH;
        end else if (w_is_lw || w_is_sw) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        if (w_is_sw) begin
          o_retired = 1'b1;
          w_next    = S_FETCH;
        end else begin
          w_next = S_WB;
        end
      end
      S_WB: begin
        o_retired = 1'b1;
        w_next    = S_FETCH;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
    if (reset) begin
      o_imem_req = 1'b0;
      o_retired  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc      <= RESET_PC;
      r_count   <= '0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else begin
      if (o_retired) r_count <= r_count + CNT_W'(1);
      case (r_state)
        S_FETCH: if (i_imem_valid) r_ir <= i_imem_data;
        S_DECODE: begin
          r_a   <= w_rs_val;
          r_b   <= w_rt_val;
          r_imm <= w_zext ? {16'd0, w_imm16} : {{16{w_imm16[15]}}, w_imm16};
          if (w_is_break) begin
            r_halted <= 1'b1;
          end else if (!w_legal) begin
            r_halted  <= 1'b1;
            r_illegal <= 1'b1;
          end
        end
        S_EXEC: begin
          r_alu <= w_alu;
          if (w_is_branch) r_pc <= w_taken ? (w_pc4 + {r_imm[29:0], 2'b00}) : w_pc4;
          else if (w_is_j) r_pc <= {w_pc4[31:28], w_target, 2'b00};
        end
        S_MEM: begin
          if (w_is_sw) r_pc <= w_pc4;
          else         r_mdr <= r_dmem[w_daddr];
        end
        S_WB: begin
          if (w_dest != 5'd0) r_regs[w_dest] <= w_is_lw ? r_mdr : r_alu;
          r_pc <= w_pc4;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && (r_state == S_MEM) && w_is_sw) r_dmem[w_daddr] <= r_b;
  end

  assign o_imem_addr    = r_pc[IMEM_AW+1:2];
  assign o_retire_count = r_count;
  assign o_halted       = r_halted;
  assign o_illegal      = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_mips32_multicycle.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mips32_multicycle
// Directed programs checked every cycle against an instruction-level model.
// Revision : 1.0
// ============================================================================
module tb_mips32_multicycle;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        i_imem_valid = 1'b1;
  logic [31:0] i_imem_data;
  logic        o_imem_req;
  logic [7:0]  o_imem_addr;
  logic        o_retired;
  logic [31:0] o_retire_count;
  logic        o_halted;
  logic        o_illegal;

  logic [31:0] rom [256];
  int checks = 0;
  int errors = 0;

  mips32_multicycle #(.IMEM_AW(8), .DMEM_AW(7), .RESET_PC(32'h0), .CNT_W(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .o_imem_req     (o_imem_req),
    .o_imem_addr    (o_imem_addr),
    .i_imem_valid   (i_imem_valid),
    .i_imem_data    (i_imem_data),
    .o_retired      (o_retired),
    .o_retire_count (o_retire_count),
    .o_halted       (o_halted),
    .o_illegal      (o_illegal)
  );

  always #5 clock = ~clock;
  assign i_imem_data = rom[o_imem_addr];

  // instruction-level model state
  logic [31:0] m_pc, m_ir, m_count;
  logic [31:0] m_regs [32];
  logic [31:0] m_dmem [128];
  bit          m_halted, m_illegal, m_busy, rst_prev;
  int          m_left, cyc;
  int          fq_addr[$], fq_cyc[$], rq_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_r(int rs, int rt, int rd, int sh, int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction
  function automatic logic [31:0] enc_i(int op, int rs, int rt, logic [15:0] imm);
    return {6'(op), 5'(rs), 5'(rt), imm};
  endfunction
  function automatic logic [31:0] enc_j(int op, logic [25:0] tgt);
    return {6'(op), tgt};
  endfunction

  localparam logic [31:0] BRK = 32'h0000_000D;

  function automatic bit is_break(logic [31:0] ir);
    return (ir[31:26] == 6'd0) && (ir[5:0] == 6'd13);
  endfunction
  function automatic bit is_legal(logic [31:0] ir);
    int op, fn;
    op = int'(ir[31:26]);
    fn = int'(ir[5:0]);
    if (op == 0) return fn inside {0, 2, 3, 6, 7, 32, 34, 36, 37, 38, 39, 42};
    if (op inside {2, 4, 8, 10, 12, 13, 14, 15, 35, 43}) return 1'b1;
`ifdef MIPS32_MC_BNE_EN
    if (op == 5) return 1'b1;
`endif
    return 1'b0;
  endfunction
  // fetch-to-retire cycle count, the fetch cycle included
  function automatic int latency(logic [31:0] ir);
    if (!is_legal(ir)) return 2;
    case (int'(ir[31:26]))
      2, 4, 5: return 3;
      35:      return 5;
      default: return 4;
    endcase
  endfunction

  task automatic wr(input logic [4:0] d, input logic [31:0] v);
    if (d != 5'd0) m_regs[d] = v;
  endtask

  task automatic model_exec(input logic [31:0] ir);
    logic [4:0]  rs, rt, rd, sh;
    logic [31:0] a, b, se, ze, npc, ea;
    rs  = ir[25:21];
    rt  = ir[20:16];
    rd  = ir[15:11];
    sh  = ir[10:6];
    a   = m_regs[rs];
    b   = m_regs[rt];
    se  = {{16{ir[15]}}, ir[15:0]};
    ze  = {16'd0, ir[15:0]};
    npc = m_pc + 32'd4;
    ea  = a + se;
    if (is_break(ir)) begin
      m_halted = 1'b1;
      m_count++;
    end else if (!is_legal(ir)) begin
      m_halted  = 1'b1;
      m_illegal = 1'b1;
    end else begin
      m_count++;
      if (ir[31:26] == 6'd0) begin
        case (int'(ir[5:0]))
          0:  wr(rd, b << sh);
          2:  wr(rd, b >> sh);
          3:  wr(rd, $signed(b) >>> sh);
          6:  wr(rd, b >> a[4:0]);
          7:  wr(rd, $signed(b) >>> a[4:0]);
          32: wr(rd, a + b);
          34: wr(rd, a - b);
          36: wr(rd, a & b);
          37: wr(rd, a | b);
          38: wr(rd, a ^ b);
          39: wr(rd, ~(a | b));
          default: wr(rd, {31'd0, $signed(a) < $signed(b)});
        endcase
      end else begin
        case (int'(ir[31:26]))
          2:  npc = {npc[31:28], ir[25:0], 2'b00};
          4:  if (a == b) npc = npc + (se << 2);
          5:  if (a != b) npc = npc + (se << 2);
          8:  wr(rt, a + se);
          10: wr(rt, {31'd0, $signed(a) < $signed(se)});
          12: wr(rt, a & ze);
          13: wr(rt, a | ze);
          14: wr(rt, a ^ ze);
          15: wr(rt, {ir[15:0], 16'd0});
          35: wr(rt, m_dmem[ea[8:2]]);
          default: m_dmem[ea[8:2]] = b;
        endcase
      end
      m_pc = npc;
    end
  endtask

  task automatic model_reset();
    m_pc = 32'd0; m_count = 32'd0; m_halted = 1'b0; m_illegal = 1'b0;
    m_busy = 1'b0; m_left = 0; m_ir = 32'd0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    fq_addr.delete(); fq_cyc.delete(); rq_cyc.delete();
  endtask

  // per-cycle compare, then advance the model across the coming edge
  always @(negedge clock) begin
    bit exp_req, exp_ret;
    cyc++;
    if (reset) begin
      chk("rst_imem_req", 32'(o_imem_req), 0);
      chk("rst_retired", 32'(o_retired), 0);
      if (rst_prev) begin
        chk("rst_count", o_retire_count, 0);
        chk("rst_halted", 32'(o_halted), 0);
        chk("rst_illegal", 32'(o_illegal), 0);
      end
      rst_prev = 1'b1;
      model_reset();
    end else begin
      rst_prev = 1'b0;
      exp_req = !m_halted && !m_busy;
      exp_ret = m_busy && (m_left == 1) && (is_legal(m_ir) || is_break(m_ir));
      chk("imem_req", 32'(o_imem_req), 32'(exp_req));
      if (exp_req) chk("imem_addr", 32'(o_imem_addr), 32'(m_pc[9:2]));
      chk("retired", 32'(o_retired), 32'(exp_ret));
      chk("retire_count", o_retire_count, m_count);
      chk("halted", 32'(o_halted), 32'(m_halted));
      chk("illegal", 32'(o_illegal), 32'(m_illegal));
      if (o_retired) rq_cyc.push_back(cyc);
      if (!m_halted) begin
        if (!m_busy) begin
          if (i_imem_valid) begin
            m_ir   = rom[m_pc[9:2]];
            m_left = latency(m_ir) - 1;
            m_busy = 1'b1;
            fq_addr.push_back(int'(m_pc[9:2]));
            fq_cyc.push_back(cyc);
          end
        end else begin
          m_left--;
          if (m_left == 0) begin
            model_exec(m_ir);
            m_busy = 1'b0;
          end
        end
      end
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = BRK;
  endtask

  task automatic do_reset();
    @(posedge clock); #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic wait_halt(input int budget, input string tag);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clock);
      if (o_halted) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_halt_timeout: halted=%0b required 1", tag, o_halted);
    end
  endtask

  task automatic cmp_regs(input string tag);
    for (int i = 0; i < 32; i++) chk($sformatf("%s_r%0d", tag, i), dut.r_regs[i], m_regs[i]);
  endtask

  function automatic int lat(int k);
    return (rq_cyc.size() > k && fq_cyc.size() > k) ? rq_cyc[k] - fq_cyc[k] : -1;
  endfunction
  function automatic int faddr(int k);
    return (fq_addr.size() > k) ? fq_addr[k] : -1;
  endfunction

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // reset with imem_valid held high, then signed arithmetic
    clear_rom();
    rom[0] = enc_i(8, 0, 1, 16'hFFFB);
    rom[1] = enc_i(10, 1, 2, 16'h0000);
    rom[2] = enc_r(0, 1, 3, 1, 3);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("first_req", 32'(o_imem_req), 1);
    chk("first_addr", 32'(o_imem_addr), 0);
    wait_halt(100, "p1");
    chk("p1_r1", dut.r_regs[1], 32'hFFFF_FFFB);
    chk("p1_r2", dut.r_regs[2], 32'd1);
    chk("p1_r3", dut.r_regs[3], 32'hFFFF_FFFD);
    chk("p1_model_r3", m_regs[3], 32'hFFFF_FFFD);
    chk("p1_lat0", lat(0), 3);
    chk("p1_lat2", lat(2), 3);
    cmp_regs("p1");

    // reset mid-instruction, then a clean full run
    do_reset();
    repeat (6) @(posedge clock);
    do_reset();
    wait_halt(100, "p1b");
    chk("p1b_count", o_retire_count, 4);
    cmp_regs("p1b");

    // remaining ALU ops, shifts, zero-extended immediates, r0 write
    clear_rom();
    rom[0]  = enc_i(15, 0, 5, 16'h8000);
    rom[1]  = enc_i(13, 5, 5, 16'h00F0);
    rom[2]  = enc_i(8, 0, 6, 16'd4);
    rom[3]  = enc_r(6, 5, 7, 0, 6);
    rom[4]  = enc_r(6, 5, 8, 0, 7);
    rom[5]  = enc_r(0, 5, 9, 8, 2);
    rom[6]  = enc_r(0, 6, 10, 3, 0);
    rom[7]  = enc_r(6, 5, 11, 0, 34);
    rom[8]  = enc_r(5, 5, 12, 0, 32);
    rom[9]  = enc_r(6, 0, 13, 0, 39);
    rom[10] = enc_r(5, 6, 14, 0, 42);
    rom[11] = enc_r(6, 5, 15, 0, 42);
    rom[12] = enc_r(5, 8, 16, 0, 36);
    rom[13] = enc_r(7, 10, 17, 0, 37);
    rom[14] = enc_r(5, 8, 18, 0, 38);
    rom[15] = enc_i(12, 8, 19, 16'hFFFF);
    rom[16] = enc_i(14, 5, 20, 16'h8001);
    rom[17] = enc_i(10, 6, 21, 16'hFFFF);
    rom[18] = enc_i(8, 0, 0, 16'd7);
    rom[19] = enc_r(0, 5, 22, 4, 3);
    do_reset();
    wait_halt(200, "p2");
    chk("p2_r7", dut.r_regs[7], 32'h0800_000F);
    chk("p2_r8", dut.r_regs[8], 32'hF800_000F);
    chk("p2_r9", dut.r_regs[9], 32'h0080_0000);
    chk("p2_r11", dut.r_regs[11], 32'h7FFF_FF14);
    chk("p2_r12", dut.r_regs[12], 32'h0000_01E0);
    chk("p2_r13", dut.r_regs[13], 32'hFFFF_FFFB);
    chk("p2_r14", dut.r_regs[14], 32'd1);
    chk("p2_r16", dut.r_regs[16], 32'h8000_0000);
    chk("p2_r18", dut.r_regs[18], 32'h7800_00FF);
    chk("p2_r19", dut.r_regs[19], 32'h0000_000F);
    chk("p2_r20", dut.r_regs[20], 32'h8000_80F1);
    chk("p2_r0", dut.r_regs[0], 32'd0);
    chk("p2_model_r11", m_regs[11], 32'h7FFF_FF14);
    cmp_regs("p2");

    // store, load, aliased load
    clear_rom();
    rom[0] = enc_i(8, 0, 1, 16'h0040);
    rom[1] = enc_i(43, 0, 1, 16'h0008);
    rom[2] = enc_i(35, 0, 4, 16'h0008);
    rom[3] = enc_i(35, 0, 5, 16'h0208);
    do_reset();
    wait_halt(100, "p3");
    chk("p3_r4", dut.r_regs[4], 32'h40);
    chk("p3_r5_alias", dut.r_regs[5], 32'h40);
    chk("p3_sw_lat", lat(1), 3);
    chk("p3_lw_lat", lat(2), 4);
    cmp_regs("p3");

    // control flow: taken/not-taken/backward beq and j
    clear_rom();
    rom[0]  = enc_i(4, 0, 0, 16'd2);
    rom[3]  = enc_j(2, 26'h10);
    rom[16] = enc_i(8, 0, 1, 16'd1);
    rom[17] = enc_i(4, 1, 0, 16'd5);
    rom[18] = enc_i(4, 0, 0, 16'hFFF8);
    do_reset();
    wait_halt(100, "p4");
    chk("p4_f1", faddr(1), 3);
    chk("p4_f2", faddr(2), 16);
    chk("p4_f4", faddr(4), 18);
    chk("p4_f5", faddr(5), 11);
    chk("p4_br_lat", lat(0), 2);
    cmp_regs("p4");

    // fetch stall of 7 cycles
    clear_rom();
    rom[0] = enc_i(8, 0, 1, 16'd3);
    rom[1] = enc_i(8, 1, 2, 16'd4);
    do_reset();
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clock);
        if (o_retired) seen = 1'b1;
      end
      chk("p5_first_retire", 32'(seen), 1);
    end
    @(posedge clock); #1 i_imem_valid = 1'b0;
    repeat (7) begin
      @(negedge clock);
      chk("p5_stall_req", 32'(o_imem_req), 1);
      chk("p5_stall_addr", 32'(o_imem_addr), 1);
      chk("p5_stall_ret", 32'(o_retired), 0);
    end
    @(posedge clock); #1 i_imem_valid = 1'b1;
    wait_halt(100, "p5");
    chk("p5_r2", dut.r_regs[2], 32'd7);
    cmp_regs("p5");

    // break after five instructions
    clear_rom();
    for (int i = 0; i < 5; i++) rom[i] = enc_i(8, 0, i + 1, 16'(10 * (i + 1)));
    do_reset();
    wait_halt(100, "p6");
    @(negedge clock);
    chk("p6_halted", 32'(o_halted), 1);
    chk("p6_illegal", 32'(o_illegal), 0);
    chk("p6_count", o_retire_count, 6);
    chk("p6_r5", dut.r_regs[5], 32'd50);
    cmp_regs("p6");

    // reset while halted, then an unsupported opcode
    clear_rom();
    rom[0] = enc_i(8, 0, 1, 16'd1);
    rom[1] = enc_i(8, 0, 2, 16'd2);
    rom[2] = 32'hFC00_0000;
    do_reset();
    wait_halt(100, "p7");
    @(negedge clock);
    chk("p7_restart_addr", faddr(0), 0);
    chk("p7_halted", 32'(o_halted), 1);
    chk("p7_illegal", 32'(o_illegal), 1);
    chk("p7_count", o_retire_count, 2);
    cmp_regs("p7");

    // unsupported R funct (sllv) as the first instruction
    clear_rom();
    rom[0] = enc_r(1, 2, 3, 0, 4);
    do_reset();
    wait_halt(50, "p8");
    @(negedge clock);
    chk("p8_illegal", 32'(o_illegal), 1);
    chk("p8_count", o_retire_count, 0);

    // op 5: bne when enabled, illegal otherwise
    clear_rom();
    rom[0] = enc_i(8, 0, 1, 16'd1);
    rom[1] = enc_i(5, 0, 1, 16'd1);
    do_reset();
    wait_halt(50, "p9");
    @(negedge clock);
`ifdef MIPS32_MC_BNE_EN
    chk("p9_illegal", 32'(o_illegal), 0);
    chk("p9_count", o_retire_count, 3);
    chk("p9_f2", faddr(2), 3);
`else
    chk("p9_illegal", 32'(o_illegal), 1);
    chk("p9_count", o_retire_count, 1);
`endif
    cmp_regs("p9");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
